divisor_secuencial: RTL and testbench



---
 rtl/divisor_secuencial_pkg.sv | 13 +
 rtl/divisor_secuencial_paso_resta.sv | 22 ++
 rtl/divisor_secuencial.sv | 142 ++++++++++++++
 tb/tb_divisor_secuencial.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/divisor_secuencial_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and default width.
package divisor_secuencial_pkg;

    localparam int unsigned DefaultWidth = 8;

    // 2'd3 is unused and recovers to StIdle.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } div_state_e;

endpackage

// File: rtl/divisor_secuencial_paso_resta.sv
// One restoring subtract-and-compare step: trial subtraction of d from the shifted remainder.
module paso_resta
    import divisor_secuencial_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic [WIDTH:0]   r_shift,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic             q_bit
);

    logic [WIDTH:0] t;

    // A restored remainder always stays below d, so only WIDTH bits are returned.
    always_comb begin
        t      = r_shift - {1'b0, d};
        q_bit  = ~t[WIDTH];
        r_next = q_bit ? t[WIDTH-1:0] : r_shift[WIDTH-1:0];
    end

endmodule

// File: rtl/divisor_secuencial.sv
// Multi-cycle unsigned divider: one restoring step per clock, registered results and done pulse.
module divisor_secuencial
    import divisor_secuencial_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] r_next;
    logic             q_bit;

    // The partial remainder's top bit is always zero between steps, so it is not stored.
    assign r_shift = {1'b0, r_q, q_q[WIDTH-1]};

    paso_resta #(
        .WIDTH (WIDTH)
    ) u_paso_resta (
        .r_shift (r_shift),
        .d       (d_q),
        .r_next  (r_next),
        .q_bit   (q_bit)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    r_d     = '0;
                    q_d     = dividend;
                    d_d     = divisor;
                    dbz_d   = 1'b0;
                    state_d = StRun;
                    if (divisor == '0) begin
                        // Zero step count: the finishing cycle loads the flagged result.
                        zero_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        zero_d = 1'b0;
                        cnt_d  = CntW'(WIDTH);
                    end
                end
            end
            StRun: begin
                if (cnt_q != '0) begin
                    r_d   = r_next;
                    q_d   = {q_q[WIDTH-2:0], q_bit};
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    state_d = StDone;
                    if (zero_q) begin
                        quot_d = '1;
                        rem_d  = q_q;
                        dbz_d  = 1'b1;
                    end else begin
                        quot_d = q_q;
                        rem_d  = r_q;
                        dbz_d  = 1'b0;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
// Randomized and directed checks of divisor_secuencial against an arithmetic reference model.
module tb_divisor_secuencial;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    divisor_secuencial #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? {W{1'b1}} : a / b;
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? a : a % b;
    endfunction

    function automatic int ref_lat(input logic [W-1:0] b);
        return (b == 0) ? 1 : W + 1;
    endfunction

    // Presents operands and pulses start across one rising edge; returns #1 after that edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // Waits (bounded) for done; lat is the number of edges expected before it appears.
    task automatic wait_done(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input int lat);
        int  k    = 0;
        bit  seen = 1'b0;
        while (!seen && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (done) seen = 1'b1;
            else      check_eq({tag, "_busy_run"}, 32'(busy), 32'd1);
        end
        check_eq({tag, "_latency"}, 32'(k), 32'(lat));
        if (seen) begin
            check_eq({tag, "_busy_done"}, 32'(busy), 32'd1);
            check_eq({tag, "_quot"}, 32'(quotient), 32'(ref_q(a, b)));
            check_eq({tag, "_rem"}, 32'(remainder), 32'(ref_r(a, b)));
            check_eq({tag, "_dbz"}, 32'(div_by_zero), 32'(b == 0));
            @(posedge clk);
            #1;
            check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
            check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
            check_eq({tag, "_hold_quot"}, 32'(quotient), 32'(ref_q(a, b)));
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        issue(a, b);
        wait_done(tag, a, b, ref_lat(b));
    endtask

    task automatic check_quiet(input string tag, input int cycles);
        int pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check_eq({tag, "_extra_done"}, 32'(pulses), 32'd0);
    endtask

    initial begin
        logic [W-1:0] cur_a;
        logic [W-1:0] cur_b;
        int           gap;
        bit           seen;

        rst_n    = 1'b0;
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd3;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_quot", 32'(quotient), 32'd0);
        check_eq("rst_rem", 32'(remainder), 32'd0);
        check_eq("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_start_ignored", 32'(busy), 32'd0);

        run_op("d100_7", 8'd100, 8'd7);
        run_op("d255_1", 8'd255, 8'd1);
        run_op("d5_9", 8'd5, 8'd9);
        run_op("d255_255", 8'd255, 8'd255);
        run_op("d0_3", 8'd0, 8'd3);
        run_op("d200_0", 8'd200, 8'd0);
        run_op("d10_3", 8'd10, 8'd3);

        // A start pulse during RUN must not disturb or queue anything.
        issue(8'd100, 8'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ign_start", 8'd100, 8'd7, W + 1 - 4);
        check_quiet("ign_start", 20);

        // Reset part-way through a division aborts it silently.
        issue(8'd200, 8'd13);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_quot", 32'(quotient), 32'd0);
        check_eq("midrst_rem", 32'(remainder), 32'd0);
        check_eq("midrst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_quiet("midrst", 15);
        run_op("d200_13", 8'd200, 8'd13);

        // Back-to-back with start held high; gap counts edges between done pulses.
        @(negedge clk);
        cur_a    = W'($urandom_range(0, 255));
        cur_b    = ($urandom_range(0, 15) == 0) ? 8'd0 : W'($urandom_range(1, 255));
        dividend = cur_a;
        divisor  = cur_b;
        start    = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            gap  = 0;
            seen = 1'b0;
            while (!seen && gap < 40) begin
                @(posedge clk);
                #1;
                gap++;
                if (done) seen = 1'b1;
            end
            check_eq("b2b_gap", 32'(gap), 32'(((i == 0) ? 1 : 2) + ref_lat(cur_b)));
            if (!seen) break;
            check_eq("b2b_quot", 32'(quotient), 32'(ref_q(cur_a, cur_b)));
            check_eq("b2b_rem", 32'(remainder), 32'(ref_r(cur_a, cur_b)));
            check_eq("b2b_dbz", 32'(div_by_zero), 32'(cur_b == 0));
            cur_a    = W'($urandom_range(0, 255));
            cur_b    = ($urandom_range(0, 15) == 0) ? 8'd0 : W'($urandom_range(1, 255));
            dividend = cur_a;
            divisor  = cur_b;
        end
        start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
